tap_detect: RTL and testbench

TAP_DETECT -- requirements
Module: tap_detect

---
 rtl/tap_pkg.sv | 24 ++
 rtl/ws_edge_sync.sv | 30 +++
 rtl/tap_detect.sv | 145 ++++++++++++++
 tb/tb_tap_detect.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
// Shared types and default constants for the tap/knock detector.
// The state literals carry an ST_ prefix so they cannot clash with the
// HOLDOFF module parameter once this package is imported.
package tap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_REPORT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } tap_state_t;

    localparam int          WIN_LEN_DEF    = 256;
    localparam logic [7:0]  TRIG_LVL_DEF   = 8'd40;
    localparam logic [15:0] ENERGY_THR_DEF = 16'd6000;
    localparam int          HOLDOFF_DEF    = 4096;

    // Magnitude of a two's-complement byte; -128 maps to 128, which fits
    // because the result is treated as unsigned.
    function automatic logic [7:0] abs8(input logic [7:0] s);
        return s[7] ? 8'(~s + 8'd1) : s;
    endfunction

endpackage

// File: rtl/ws_edge_sync.sv
// Brings the IIS word-select into clk_i and emits a one-cycle pulse on its
// falling edge. The pulse appears 3 clk_i edges after ws_i falls.
// Flops reset to 1 so releasing reset with ws_i high gives no false edge.
module ws_edge_sync (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ws_i,
    output logic fall_o
);

    logic ws_s1;
    logic ws_s2;
    logic ws_s3;

    // Two synchronizer stages, one history stage, registered edge pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ws_s1  <= 1'b1;
            ws_s2  <= 1'b1;
            ws_s3  <= 1'b1;
            fall_o <= 1'b0;
        end else begin
            ws_s1  <= ws_i;
            ws_s2  <= ws_s1;
            ws_s3  <= ws_s2;
            fall_o <= ws_s3 & ~ws_s2;
        end
    end

endmodule

// File: rtl/tap_detect.sv
// Tap detector: triggers on a loud sample, sums |sample| over a window,
// reports energy/peak/defect, then ignores a number of strobes.
// Optional macro TAP_PEAK_TRACK_EN builds the peak tracker; without it
// peak_o is tied to 0.
//
//  state      | meaning
//  ST_IDLE    | waiting for a valid sample with |s| >= TRIG_LVL
//  ST_CAPTURE | accumulating window samples until WIN_LEN are in
//  ST_REPORT  | one cycle: publish results, pulse result_valid_o
//  ST_HOLDOFF | counting HOLDOFF strobes before re-arming
module tap_detect
    import tap_pkg::*;
#(
    parameter int          WIN_LEN    = WIN_LEN_DEF,
    parameter logic [7:0]  TRIG_LVL   = TRIG_LVL_DEF,
    parameter logic [15:0] ENERGY_THR = ENERGY_THR_DEF,
    parameter int          HOLDOFF    = HOLDOFF_DEF,
    localparam int         EW         = 8 + $clog2(WIN_LEN)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          ws_i,
    input  logic [7:0]    data_i,
    input  logic          data_en_i,
    output logic [EW-1:0] energy_o,
    output logic [7:0]    peak_o,
    output logic          defect_o,
    output logic          result_valid_o,
    output logic          busy_o
);

    // One counter serves both the window and the holdoff phases.
    localparam int CNT_W = ($clog2(WIN_LEN + 1) > $clog2(HOLDOFF + 1)) ?
                           $clog2(WIN_LEN + 1) : $clog2(HOLDOFF + 1);

    tap_state_t       state_q;
    tap_state_t       state_d;
    logic             strobe;
    logic [7:0]       mag;
    logic             smp_vld;
    logic             smp_gap;
    logic             trig;
    logic [EW-1:0]    acc;
    logic [CNT_W-1:0] cnt;

    ws_edge_sync u_ws_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .ws_i    (ws_i),
        .fall_o  (strobe)
    );

    assign mag     = abs8(data_i);
    assign smp_vld = strobe & data_en_i;
    assign smp_gap = strobe & ~data_en_i;
    assign trig    = smp_vld & (mag >= TRIG_LVL);

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; the last window sample moves straight to REPORT so
    // result_valid_o lands two cycles after that sample's strobe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (trig) state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (smp_gap)
                    state_d = ST_IDLE;
                else if (smp_vld && cnt == CNT_W'(WIN_LEN - 1))
                    state_d = ST_REPORT;
            end
            ST_REPORT:  state_d = ST_HOLDOFF;
            ST_HOLDOFF: if (strobe && cnt == CNT_W'(HOLDOFF - 1)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        busy_o = (state_q != ST_IDLE);
    end

    // Window accumulator, strobe counter and published energy/defect.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc            <= '0;
            cnt            <= '0;
            energy_o       <= '0;
            defect_o       <= 1'b0;
            result_valid_o <= 1'b0;
        end else begin
            result_valid_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        acc <= EW'(mag);
                        cnt <= CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    if (smp_vld) begin
                        acc <= acc + EW'(mag);
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_REPORT: begin
                    energy_o       <= acc;
                    defect_o       <= (32'(acc) < 32'(ENERGY_THR));
                    result_valid_o <= 1'b1;
                    cnt            <= '0;
                end
                ST_HOLDOFF: begin
                    if (strobe) cnt <= cnt + CNT_W'(1);
                end
                default: cnt <= '0;
            endcase
        end
    end

`ifdef TAP_PEAK_TRACK_EN
    logic [7:0] pk;

    // Running window maximum and its published copy.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pk     <= '0;
            peak_o <= '0;
        end else begin
            case (state_q)
                ST_IDLE:    if (trig) pk <= mag;
                ST_CAPTURE: if (smp_vld && mag > pk) pk <= mag;
                ST_REPORT:  peak_o <= pk;
                default:    pk <= pk;
            endcase
        end
    end
`else
    assign peak_o = 8'd0;
`endif

endmodule

// File: tb/tb_tap_detect.sv
// Directed bench for tap_detect with WIN_LEN=16, HOLDOFF=4.
// A second instance with ENERGY_THR=2048 shares the stimulus so the
// defect flag is seen both set and clear.
module tb_tap_detect;
    import tap_pkg::*;

    localparam int EW = 12;
`ifdef TAP_PEAK_TRACK_EN
    localparam bit PK_EN = 1'b1;
`else
    localparam bit PK_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          ws_i;
    logic [7:0]    data_i;
    logic          data_en_i;
    logic [EW-1:0] energy_o;
    logic [7:0]    peak_o;
    logic          defect_o;
    logic          result_valid_o;
    logic          busy_o;
    logic [EW-1:0] energy_b;
    logic [7:0]    peak_b;
    logic          defect_b;
    logic          valid_b;
    logic          busy_b;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int lat;
    int p0;

    always #5 clk_i = ~clk_i;

    tap_detect #(.WIN_LEN(16), .TRIG_LVL(8'd40), .ENERGY_THR(16'd6000), .HOLDOFF(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ws_i(ws_i), .data_i(data_i),
        .data_en_i(data_en_i), .energy_o(energy_o), .peak_o(peak_o),
        .defect_o(defect_o), .result_valid_o(result_valid_o), .busy_o(busy_o)
    );

    tap_detect #(.WIN_LEN(16), .TRIG_LVL(8'd40), .ENERGY_THR(16'd2048), .HOLDOFF(4)) dut_b (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ws_i(ws_i), .data_i(data_i),
        .data_en_i(data_en_i), .energy_o(energy_b), .peak_o(peak_b),
        .defect_o(defect_b), .result_valid_o(valid_b), .busy_o(busy_b)
    );

    always @(negedge clk_i) if (result_valid_o === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One IIS word: ws high for 3 cycles, then fall with new data; returns
    // 6 cycles after the fall so any report has already pulsed.
    task automatic send(input logic [7:0] d, input logic en);
        @(negedge clk_i);
        ws_i = 1'b1;
        repeat (3) @(negedge clk_i);
        data_i    = d;
        data_en_i = en;
        ws_i      = 1'b0;
        repeat (6) @(negedge clk_i);
    endtask

    initial begin
        rst_n_i   = 1'b0;
        ws_i      = 1'b1;
        data_i    = 8'd0;
        data_en_i = 1'b0;
        #1;
        check("rst_energy", 32'(energy_o), 0);
        check("rst_peak", 32'(peak_o), 0);
        check("rst_defect", 32'(defect_o), 0);
        check("rst_valid", 32'(result_valid_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk_i);

        // Window 1: 50 then 15x 10
        send(8'd50, 1'b1);
        check("w1_busy_after_trig", 32'(busy_o), 1);
        for (int i = 0; i < 14; i++) send(8'd10, 1'b1);
        check("w1_no_early_pulse", 32'(pulses), 0);
        @(negedge clk_i);
        ws_i = 1'b1;
        repeat (3) @(negedge clk_i);
        data_i = 8'd10;
        ws_i   = 1'b0;
        lat    = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            if (result_valid_o === 1'b1 && lat == 0) lat = i;
        end
        check("w1_latency", 32'(lat), 5);
        check("w1_pulses", 32'(pulses), 1);
        check("w1_energy", 32'(energy_o), 200);
        check("w1_peak", 32'(peak_o), PK_EN ? 50 : 0);
        check("w1_defect", 32'(defect_o), 1);
        check("w1_defect_b", 32'(defect_b), 1);
        check("w1_busy_holdoff", 32'(busy_o), 1);

        // Holdoff: trigger on strobe 1 ignored, strobes 2..4 without data
        send(8'd100, 1'b1);
        check("ho_busy_s1", 32'(busy_o), 1);
        send(8'd0, 1'b0);
        send(8'd0, 1'b0);
        check("ho_busy_s3", 32'(busy_o), 1);
        send(8'd0, 1'b0);
        check("ho_idle_s4", 32'(busy_o), 0);

        // Window 2: strobe 5 triggers, 16x -128
        send(8'h80, 1'b1);
        check("w2_busy_s5", 32'(busy_o), 1);
        for (int i = 0; i < 15; i++) send(8'h80, 1'b1);
        check("w2_pulses", 32'(pulses), 2);
        check("w2_energy", 32'(energy_o), 2048);
        check("w2_peak", 32'(peak_o), PK_EN ? 128 : 0);
        check("w2_defect", 32'(defect_o), 1);
        check("w2_defect_b_at_thr", 32'(defect_b), 0);
        for (int i = 0; i < 4; i++) send(8'd0, 1'b0);
        check("w2_idle", 32'(busy_o), 0);

        // Sub-threshold samples
        send(8'd39, 1'b1);
        check("sub_pos_busy", 32'(busy_o), 0);
        send(8'hD9, 1'b1);
        check("sub_neg_busy", 32'(busy_o), 0);
        check("sub_pulses", 32'(pulses), 2);

        // Abort: data_en_i drops at sample 7
        send(8'd60, 1'b1);
        for (int i = 0; i < 5; i++) send(8'd20, 1'b1);
        check("ab_busy_before", 32'(busy_o), 1);
        send(8'd20, 1'b0);
        check("ab_idle", 32'(busy_o), 0);
        check("ab_pulses", 32'(pulses), 2);
        check("ab_energy_hold", 32'(energy_o), 2048);
        check("ab_peak_hold", 32'(peak_o), PK_EN ? 128 : 0);

        // Reset mid-capture; trigger exactly at |-40| = TRIG_LVL
        send(8'hD8, 1'b1);
        check("rc_trig_at_lvl", 32'(busy_o), 1);
        for (int i = 0; i < 3; i++) send(8'd40, 1'b1);
        @(negedge clk_i);
        rst_n_i = 1'b0;
        ws_i    = 1'b1;
        #1;
        check("rc_energy", 32'(energy_o), 0);
        check("rc_peak", 32'(peak_o), 0);
        check("rc_defect", 32'(defect_o), 0);
        check("rc_busy", 32'(busy_o), 0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("rc_no_false_strobe", 32'(busy_o), 0);
        p0 = pulses;
        for (int i = 0; i < 16; i++) send(8'd45, 1'b1);
        check("rc_pulses", 32'(pulses - p0), 1);
        check("rc_energy_new", 32'(energy_o), 720);
        check("rc_peak_new", 32'(peak_o), PK_EN ? 45 : 0);
        check("rc_defect_new", 32'(defect_o), 1);
        check("rc_defect_b_new", 32'(defect_b), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
